// File: rtl/i2c_cmd_sequencer_if.sv
// Command/launch bus of the I2C command sequencer.
//   cmd_*  : host-side valid/ready command channel (7-bit address + data byte).
//   mst_*  : launch/completion channel towards the I2C master.
// Modports:
//   master : host/master-side view (drives commands and completions).
//   slave  : sequencer-side view.
interface i2c_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       mst_start;
    logic [7:0] mst_slave_addr;
    logic [7:0] mst_data;
    logic       mst_done;
    logic       mst_nack;

    modport master (
        output cmd_valid, cmd_addr, cmd_data, mst_done, mst_nack,
        input  cmd_ready, mst_start, mst_slave_addr, mst_data
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data, mst_done, mst_nack,
        output cmd_ready, mst_start, mst_slave_addr, mst_data
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Command queue and launch controller in front of an I2C master.
// Buffers host write commands in a DEPTH-entry FIFO, launches them one at a
// time, retries NACKed transfers up to MAX_RETRY times, times out an attempt
// after TIMEOUT cycles without completion and reports failures.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : command channel and master launch channel (slave modport)
//   busy         : state not idle or FIFO non-empty
//   level        : FIFO occupancy
//   err_valid    : one-cycle failure pulse
//   err_code     : 01 = NACK after retries, 10 = timeout (held)
//   err_addr     : address of the failed command (held)
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    reset_n,
    i2c_cmd_sequencer_if.slave      bus,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_valid,
    output logic [1:0]              err_code,
    output logic [6:0]              err_addr
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

    state_e          state_q, state_d;
    logic [14:0]     mem_q [DEPTH];
    logic [14:0]     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      mst_addr_q, mst_addr_d;
    logic [7:0]      mst_data_q, mst_data_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [6:0]      err_addr_q, err_addr_d;
    logic            push, pop, full;

    // Full blocks a push even when a pop retires in the same cycle.
    assign full  = (level_q == LW'(DEPTH));
    assign push  = bus.cmd_valid && !full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_addr, bus.cmd_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        mst_addr_d  = mst_addr_q;
        mst_data_d  = mst_data_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    retry_d    = '0;
                    mst_addr_d = {1'b0, mem_q[rd_ptr_q][14:8]};
                    mst_data_d = mem_q[rd_ptr_q][7:0];
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // Completion wins over a timeout landing on the same cycle.
                if (bus.mst_done) begin
                    if (!bus.mst_nack) begin
                        pop     = 1'b1;
                        state_d = StIdle;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StLaunch;
                    end else begin
                        pop         = 1'b1;
                        err_valid_d = 1'b1;
                        err_code_d  = 2'b01;
                        err_addr_d  = mem_q[rd_ptr_q][14:8];
                        state_d     = StIdle;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    pop         = 1'b1;
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b10;
                    err_addr_d  = mem_q[rd_ptr_q][14:8];
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            mst_addr_q  <= '0;
            mst_data_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            mst_addr_q  <= mst_addr_d;
            mst_data_q  <= mst_data_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Decoded from the state register so reset drops it asynchronously.
    assign bus.mst_start      = (state_q == StLaunch);
    assign bus.cmd_ready      = !full;
    assign bus.mst_slave_addr = mst_addr_q;
    assign bus.mst_data       = mst_data_q;
    assign busy               = (state_q != StIdle) || (level_q != '0);
    assign level              = level_q;
    assign err_valid          = err_valid_q;
    assign err_code           = err_code_q;
    assign err_addr           = err_addr_q;
endmodule
